des_sbox_seq: RTL and testbench

DES_SBOX_SEQ -- requirements
Module: des_sbox_seq

---
 rtl/des_pkg.sv | 35 +++
 rtl/des_sbox_bank.sv | 19 +
 rtl/des_sbox_seq.sv | 102 ++++++++++
 tb/tb_des_sbox_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants, FSM encoding and the bit-exact DES S-box tables for the
// sequential S-box evaluator.
package des_pkg;

  localparam int NUM_SBOX   = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Each box: 64 nibbles, row 0 col 0 in the most significant nibble, rows in order.
  localparam logic [0:NUM_SBOX-1][255:0] SBOX_TBL = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Row is the outer bit pair {b6,b1}, column the inner four bits.
  function automatic logic [SBOX_OUT_W-1:0] sbox_lookup(input int box,
                                                         input logic [SBOX_IN_W-1:0] x);
    logic [5:0] k;
    k = {x[5], x[0], x[4:1]};
    return SBOX_TBL[box][255 - 4*int'(k) -: 4];
  endfunction

endpackage

// File: rtl/des_sbox_bank.sv
// Combinational S-box bank: evaluates all eight DES tables on one 6-bit input
// and selects the result of the box named by idx.
module des_sbox_bank
  import des_pkg::*;
(
  input  logic [2:0]            idx,
  input  logic [SBOX_IN_W-1:0]  sin,
  output logic [SBOX_OUT_W-1:0] sout
);

  logic [SBOX_OUT_W-1:0] box_out [NUM_SBOX];

  for (genvar b = 0; b < NUM_SBOX; b++) begin : g_box
    assign box_out[b] = sbox_lookup(b, sin);
  end

  assign sout = box_out[idx];

endmodule

// File: rtl/des_sbox_seq.sv
// Sequential DES S-box evaluator: latches 48 key-mixed bits and resolves the
// eight S-boxes LANES at a time, handing the 32-bit result out on a valid/ready port.
module des_sbox_seq
  import des_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:1] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:1] out_data,
  output logic        busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end

  state_e      state, state_nxt;
  logic [2:0]  idx;
  logic [48:1] din;
  logic [32:1] dout;
  logic        started;
  logic        last_step;

  logic [2:0]            lane_idx [LANES];
  logic [SBOX_OUT_W-1:0] lane_nib [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = idx + 3'(l);
    des_sbox_bank u_bank (
      .idx  (lane_idx[l]),
      .sin  (din[48 - 6*int'(lane_idx[l]) -: 6]),
      .sout (lane_nib[l])
    );
  end

  assign last_step = (idx == 3'(NUM_SBOX - LANES));
  // started keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = started && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid && in_ready) state_nxt = RUN;
        RUN:     if (last_step)            state_nxt = DONE;
        DONE:    if (out_ready)            state_nxt = IDLE;
        default:                           state_nxt = IDLE;
      endcase
    end
  end

  // Each lookup lands in the fixed nibble slot of its box, so no shifting is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      din  <= '0;
      dout <= '0;
    end else if (clear) begin
      idx  <= '0;
      dout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            din <= in_data;
            idx <= '0;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            dout[32 - 4*int'(lane_idx[l]) -: 4] <= lane_nib[l];
          end
          idx <= idx + 3'(LANES);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed bench: runs LANES = 1, 2, 4 and 8 side by side on shared stimulus and
// checks results, latency, backpressure, clear and reset against hand-derived values.
module tb_des_sbox_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [48:1] in_data = '0;
  logic        out_ready = 1'b1;

  logic [3:0]        ir, ov, bz;
  logic [3:0][31:0]  od;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .busy      (bz[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted operation on all four instances with out_ready held high.
  task automatic applyStimulus(input string tag, input logic [48:1] data, input logic [31:0] expv);
    int lat [4];
    bit seen [4];
    for (int d = 0; d < 4; d++) begin
      lat[d]  = -1;
      seen[d] = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, "_ready"}, 64'(ir), 64'hF);
    in_data   = data;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (!seen[d] && ov[d]) begin
          seen[d] = 1'b1;
          lat[d]  = c - 1;
          checkOutput($sformatf("%s_L%0d_data", tag, 1 << d), 64'(od[d]), 64'(expv));
        end
      end
    end
    for (int d = 0; d < 4; d++)
      checkOutput($sformatf("%s_L%0d_latency", tag, 1 << d), 64'(lat[d]), 64'(8 >> d));
  endtask

  localparam logic [48:1] VEC_D = {6'h21, 6'h20, 6'h1E, 6'h01, 6'h02, 6'h3E, 6'h15, 6'h2A};
  localparam logic [48:1] VEC_E = {6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01, 6'h01};

  initial begin
    int pulses;
    int waited;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready",  64'(ir), 64'h0);
    checkOutput("rst_out_valid", 64'(ov), 64'h0);
    checkOutput("rst_busy",      64'(bz), 64'h0);
    checkOutput("rst_out_data",  64'(od[0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rel_in_ready_low", 64'(ir), 64'h0);
    @(negedge clk);
    checkOutput("rel_in_ready_high", 64'(ir), 64'hF);

    applyStimulus("zero",  48'h0,             32'hEFA72C4D);
    applyStimulus("s1one", 48'h0400_0000_0000, 32'h0FA72C4D);
    applyStimulus("ones",  48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
    applyStimulus("mixed", VEC_D,             32'hF08DC65C);
    applyStimulus("allone", VEC_E,            32'h03DDEAD1);

    // Backpressure: hold results in DONE while in_valid pulses with other data.
    out_ready = 1'b0;
    @(negedge clk);
    in_data  = VEC_D;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!ov[0] && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("bp_reached_done", 64'(ov), 64'hF);
    for (int c = 0; c < 5; c++) begin
      in_data  = 48'hFFFF_FFFF_FFFF;
      in_valid = c[0];
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_data_L1", c), 64'(od[0]), 64'hF08DC65C);
      checkOutput($sformatf("bp_hold%0d_data_L8", c), 64'(od[3]), 64'hF08DC65C);
      checkOutput($sformatf("bp_hold%0d_ready", c),   64'(ir), 64'h0);
      checkOutput($sformatf("bp_hold%0d_valid", c),   64'(ov), 64'hF);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_release_ready", 64'(ir), 64'hF);
    checkOutput("bp_release_busy",  64'(bz), 64'h0);
    checkOutput("bp_release_valid", 64'(ov), 64'h0);

    // Clear at idx 3 of the LANES=1 run, together with a new in_valid.
    @(negedge clk);
    in_data  = VEC_D;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = VEC_E;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_busy",     64'(bz), 64'h0);
    checkOutput("clr_valid",    64'(ov), 64'h0);
    checkOutput("clr_data_L1",  64'(od[0]), 64'h0);
    checkOutput("clr_data_L4",  64'(od[2]), 64'h0);
    checkOutput("clr_ready",    64'(ir), 64'hF);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov != 4'h0) pulses++;
    end
    checkOutput("clr_no_valid", 64'(pulses), 64'h0);

    // Reset mid-RUN.
    in_data  = 48'h0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstrun_valid", 64'(ov), 64'h0);
    checkOutput("rstrun_busy",  64'(bz), 64'h0);
    checkOutput("rstrun_ready", 64'(ir), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstrun_ready_back", 64'(ir), 64'hF);

    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    in_data   = VEC_E;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!ov[0] && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rstdone_reached", 64'(ov[0]), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstdone_valid", 64'(ov), 64'h0);
    checkOutput("rstdone_busy",  64'(bz), 64'h0);
    checkOutput("rstdone_data",  64'(od[0]), 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    applyStimulus("after_rst_a", VEC_D, 32'hF08DC65C);
    applyStimulus("after_rst_b", VEC_E, 32'h03DDEAD1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
